// File: rtl/conv_pkg.sv
// Shared constants, state encoding and address helper for the conv + pool sequencer.
package conv_pkg;

    localparam int IMG_W     = 14;
    localparam int K         = 3;
    localparam int MAC_LAT   = 2;
    localparam int OUT_W     = (IMG_W - K + 1) / 2;
    localparam int PIX_CNT_W = 8;
    localparam int RB_AW     = 6;
    localparam int COORD_W   = 4;
    localparam int NUM_PIX   = IMG_W * IMG_W;
    localparam int NUM_WGT   = K * K;
    localparam int NUM_OUT   = OUT_W * OUT_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    // Pooled-output address of the 2x2 block that contains conv position (cr, cc).
    function automatic logic [RB_AW-1:0] rb_addr(input logic [COORD_W-1:0] cr,
                                                 input logic [COORD_W-1:0] cc);
        return RB_AW'(cr[COORD_W-1:1]) * RB_AW'(OUT_W) + RB_AW'(cc[COORD_W-1:1]);
    endfunction

endpackage

// File: rtl/conv_pool_delay.sv
// Fixed-depth shift register carrying a conv issue {valid, row, col} across the MAC latency.
module conv_pool_delay #(
    parameter int DEPTH = 2,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [CW-1:0] in_row,
    input  logic [CW-1:0] in_col,
    output logic          out_valid,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col
);

    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [DEPTH-1:0][CW-1:0] row_q, row_d;
    logic [DEPTH-1:0][CW-1:0] col_q, col_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign vld_d[gi] = in_valid;
                assign row_d[gi] = in_row;
                assign col_d[gi] = in_col;
            end else begin : g_tail
                assign vld_d[gi] = vld_q[gi-1];
                assign row_d[gi] = row_q[gi-1];
                assign col_d[gi] = col_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            vld_q <= vld_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_row   = row_q[DEPTH-1];
    assign out_col   = col_q[DEPTH-1];

endmodule

// File: rtl/conv_pool_ctrl.sv
// Frame sequencer for the 14x14 conv + 2x2 max-pool datapath: pixel counting,
// window issue, pool/result-buffer control and the 36-word readout burst.
module conv_pool_ctrl
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 busy,
    output logic                 wgt_wr_en,
    output logic [3:0]           wgt_wr_idx,
    output logic                 lb_wr_en,
    output logic [COORD_W-1:0]   lb_wr_row,
    output logic [COORD_W-1:0]   lb_wr_col,
    output logic                 conv_en,
    output logic [COORD_W-1:0]   conv_row,
    output logic [COORD_W-1:0]   conv_col,
    output logic                 pool_en,
    output logic                 pool_load,
    output logic [2:0]           pool_col,
    output logic                 rb_wr_en,
    output logic [RB_AW-1:0]     rb_wr_addr,
    output logic                 rb_rd_en,
    output logic [RB_AW-1:0]     rb_rd_addr,
    output logic                 out_valid,
    output logic                 frame_done
);

    state_t                 state_q, state_d;
    logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [COORD_W-1:0]     row_q, row_d, col_q, col_d;
    logic                   conv_en_q, conv_en_d;
    logic [COORD_W-1:0]     conv_row_q, conv_row_d, conv_col_q, conv_col_d;
    logic [RB_AW-1:0]       rd_cnt_q, rd_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   frame_done_q, frame_done_d;

    logic                   accept, last_pix, rd_en, last_wr;
    logic                   dly_valid;
    logic [COORD_W-1:0]     dly_row, dly_col;

    // Beats are only taken while loading; reset also masks the combinational strobes.
    always_comb begin
        accept    = in_valid && !rst && (state_q == IDLE || state_q == LOAD);
        last_pix  = (pix_cnt_q == PIX_CNT_W'(NUM_PIX - 1));
        pix_cnt_d = pix_cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        if (accept) begin
            if (last_pix) begin
                pix_cnt_d = '0;
                row_d     = '0;
                col_d     = '0;
            end else begin
                pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
                if (col_q == COORD_W'(IMG_W - 1)) begin
                    col_d = '0;
                    row_d = row_q + COORD_W'(1);
                end else begin
                    col_d = col_q + COORD_W'(1);
                end
            end
        end
        conv_en_d  = accept && (row_q >= COORD_W'(K - 1)) && (col_q >= COORD_W'(K - 1));
        conv_row_d = conv_en_d ? row_q - COORD_W'(K - 1) : '0;
        conv_col_d = conv_en_d ? col_q - COORD_W'(K - 1) : '0;
    end

    conv_pool_delay #(
        .DEPTH (MAC_LAT),
        .CW    (COORD_W)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (conv_en_q),
        .in_row    (conv_row_q),
        .in_col    (conv_col_q),
        .out_valid (dly_valid),
        .out_row   (dly_row),
        .out_col   (dly_col)
    );

    // First element of a 2x2 block loads the accumulator; the last one commits it.
    always_comb begin
        pool_en    = dly_valid;
        pool_load  = dly_valid && !dly_row[0] && !dly_col[0];
        pool_col   = dly_valid ? dly_col[COORD_W-1:1] : '0;
        rb_wr_en   = dly_valid && dly_row[0] && dly_col[0];
        rb_wr_addr = rb_wr_en ? rb_addr(dly_row, dly_col) : '0;
        last_wr    = rb_wr_en && (rb_wr_addr == RB_AW'(NUM_OUT - 1));
    end

    always_comb begin
        rd_en        = (state_q == OUTPUT) && (rd_cnt_q < RB_AW'(NUM_OUT));
        rd_cnt_d     = (state_q != OUTPUT) ? '0 :
                       rd_en ? rd_cnt_q + RB_AW'(1) : rd_cnt_q;
        out_valid_d  = rd_en;
        frame_done_d = rd_en && (rd_cnt_q == RB_AW'(NUM_OUT - 1));
    end

    // OUTPUT is held until the last out_valid so the burst never leaves the state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)             state_d = LOAD;
            LOAD:    if (accept && last_pix) state_d = DRAIN;
            DRAIN:   if (last_wr)            state_d = OUTPUT;
            OUTPUT:  if (frame_done_q)       state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            conv_en_q    <= 1'b0;
            conv_row_q   <= '0;
            conv_col_q   <= '0;
            rd_cnt_q     <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            conv_en_q    <= conv_en_d;
            conv_row_q   <= conv_row_d;
            conv_col_q   <= conv_col_d;
            rd_cnt_q     <= rd_cnt_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign wgt_wr_en  = accept && (pix_cnt_q < PIX_CNT_W'(NUM_WGT));
    assign wgt_wr_idx = wgt_wr_en ? pix_cnt_q[3:0] : 4'd0;
    assign lb_wr_en   = accept;
    assign lb_wr_row  = accept ? row_q : '0;
    assign lb_wr_col  = accept ? col_q : '0;
    assign conv_en    = conv_en_q;
    assign conv_row   = conv_row_q;
    assign conv_col   = conv_col_q;
    assign rb_rd_en   = rd_en;
    assign rb_rd_addr = rd_en ? rd_cnt_q : '0;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_pool_ctrl.sv
// Bench for conv_pool_ctrl: frame-schedule model compared every cycle, plus literal timing pins.
module tb_conv_pool_ctrl;

    localparam int MAC_LAT = 2;
    localparam int IMG_W   = 14;
    localparam int NPIX    = 196;
    localparam int NOUT    = 36;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       busy, wgt_wr_en, lb_wr_en, conv_en, pool_en, pool_load;
    logic       rb_wr_en, rb_rd_en, out_valid, frame_done;
    logic [3:0] wgt_wr_idx, lb_wr_row, lb_wr_col, conv_row, conv_col;
    logic [2:0] pool_col;
    logic [5:0] rb_wr_addr, rb_rd_addr;

    always #5 clk = ~clk;

    conv_pool_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .busy       (busy),
        .wgt_wr_en  (wgt_wr_en),
        .wgt_wr_idx (wgt_wr_idx),
        .lb_wr_en   (lb_wr_en),
        .lb_wr_row  (lb_wr_row),
        .lb_wr_col  (lb_wr_col),
        .conv_en    (conv_en),
        .conv_row   (conv_row),
        .conv_col   (conv_col),
        .pool_en    (pool_en),
        .pool_load  (pool_load),
        .pool_col   (pool_col),
        .rb_wr_en   (rb_wr_en),
        .rb_wr_addr (rb_wr_addr),
        .rb_rd_en   (rb_rd_en),
        .rb_rd_addr (rb_rd_addr),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int dut_fd_cnt = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Model: frame phase (0 idle, 1 loading, 2 after last pixel) and a schedule of future events.
    int m_state = 0, m_pix = 0, m_T = 0, m_end = 0;
    int ev_conv[int];
    int ev_pool[int];
    int ev_rd[int];
    bit ev_ov[int];
    bit ev_fd[int];
    int beat30 = -1, first_conv = -1, n_conv = 0, n_rbw = 0, first_ov = -1, fd_cyc = -1;
    int pin46 = -1, pin57 = -1;

    task automatic clear_stats();
        first_conv = -1; n_conv = 0; n_rbw = 0; first_ov = -1; fd_cyc = -1;
        beat30 = -1; pin46 = -1; pin57 = -1;
    endtask

    initial begin : monitor
        int  t, p, r, c, v, cr, cc;
        bit  acc, e;
        forever begin
            @(negedge clk);
            t = cyc;
            if (rst) begin
                m_state = 0; m_pix = 0;
                ev_conv.delete(); ev_pool.delete(); ev_rd.delete();
                ev_ov.delete(); ev_fd.delete();
                clear_stats();
                chk("rst_flags", {busy, wgt_wr_en, lb_wr_en, conv_en, pool_en, pool_load,
                                  rb_wr_en, rb_rd_en, out_valid, frame_done}, 0);
                chk("rst_idx", {wgt_wr_idx, lb_wr_row, lb_wr_col, conv_row, conv_col}, 0);
                chk("rst_addr", {pool_col, rb_wr_addr, rb_rd_addr}, 0);
            end else begin
                acc = in_valid && (m_state != 2);
                chk("busy", busy, int'(m_state != 0));
                chk("wgt_wr_en", wgt_wr_en, int'(acc && m_pix < 9));
                if (acc && m_pix < 9) chk("wgt_wr_idx", wgt_wr_idx, m_pix);
                chk("lb_wr_en", lb_wr_en, int'(acc));
                if (acc) begin
                    chk("lb_wr_row", lb_wr_row, m_pix / IMG_W);
                    chk("lb_wr_col", lb_wr_col, m_pix % IMG_W);
                end
                e = ev_conv.exists(t);
                chk("conv_en", conv_en, int'(e));
                if (e) begin
                    chk("conv_row", conv_row, ev_conv[t] / 16);
                    chk("conv_col", conv_col, ev_conv[t] % 16);
                end
                e  = ev_pool.exists(t);
                v  = e ? ev_pool[t] : 0;
                cr = v / 16;
                cc = v % 16;
                chk("pool_en", pool_en, int'(e));
                chk("pool_load", pool_load, int'(e && cr % 2 == 0 && cc % 2 == 0));
                if (e) chk("pool_col", pool_col, cc / 2);
                chk("rb_wr_en", rb_wr_en, int'(e && cr % 2 == 1 && cc % 2 == 1));
                if (e && cr % 2 == 1 && cc % 2 == 1) chk("rb_wr_addr", rb_wr_addr, (cr / 2) * 6 + cc / 2);
                e = ev_rd.exists(t);
                chk("rb_rd_en", rb_rd_en, int'(e));
                if (e) chk("rb_rd_addr", rb_rd_addr, ev_rd[t]);
                chk("out_valid", out_valid, int'(ev_ov.exists(t)));
                chk("frame_done", frame_done, int'(ev_fd.exists(t)));

                // Literal pins observed from the DUT's own event stream.
                if (conv_en) begin
                    n_conv++;
                    if (first_conv < 0) first_conv = t;
                    if (conv_row == 4 && conv_col == 6) pin46 = t + MAC_LAT;
                    if (conv_row == 5 && conv_col == 7) pin57 = t + MAC_LAT;
                end
                if (t == pin46) begin
                    chk("pin_pool_load_4_6", pool_load, 1);
                    chk("pin_pool_col_4_6", pool_col, 3);
                end
                if (t == pin57) begin
                    chk("pin_rb_wr_en_5_7", rb_wr_en, 1);
                    chk("pin_rb_wr_addr_5_7", rb_wr_addr, 15);
                end
                if (rb_wr_en) begin
                    chk("rb_wr_order", rb_wr_addr, n_rbw);
                    n_rbw++;
                end
                if (out_valid && first_ov < 0) first_ov = t;
                if (frame_done) begin
                    fd_cyc = t;
                    dut_fd_cnt++;
                end

                if (acc) begin
                    if (m_state == 0) begin
                        m_state = 1;
                        m_pix   = 0;
                        clear_stats();
                    end
                    p = m_pix; r = p / IMG_W; c = p % IMG_W;
                    if (p == 30) beat30 = t;
                    if (r >= 2 && c >= 2) begin
                        ev_conv[t + 1]           = (r - 2) * 16 + (c - 2);
                        ev_pool[t + 1 + MAC_LAT] = (r - 2) * 16 + (c - 2);
                    end
                    if (p == NPIX - 1) begin
                        m_state = 2;
                        m_T     = t;
                        m_end   = t + 38 + MAC_LAT;
                        for (int k = 0; k < NOUT; k++) begin
                            ev_rd[t + 2 + MAC_LAT + k] = k;
                            ev_ov[t + 3 + MAC_LAT + k] = 1'b1;
                        end
                        ev_fd[m_end] = 1'b1;
                    end else begin
                        m_pix++;
                    end
                end else if (m_state == 2 && t == m_end) begin
                    chk("frame_conv_count", n_conv, 144);
                    chk("frame_rbw_count", n_rbw, 36);
                    chk("first_conv_after_beat30", first_conv - beat30, 1);
                    chk("first_out_valid_rel_T", first_ov - m_T, 5);
                    chk("frame_done_rel_T", fd_cyc - m_T, 40);
                    m_state = 0;
                    m_pix   = 0;
                end
            end
        end
    end

    task automatic step(input bit v);
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int start_cnt);
        int n;
        n = 0;
        while (dut_fd_cnt == start_cnt && n < 80) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (dut_fd_cnt == start_cnt) begin
            errors++;
            $display("FAIL frame_done_timeout cyc=%0d actual=none required=pulse", cyc);
        end
    endtask

    task automatic send_frame(input int s0_at, input int s0_len, input int s1_at,
                              input int s1_len, input bit hold_after);
        int start_cnt;
        start_cnt = dut_fd_cnt;
        for (int p = 0; p < NPIX; p++) begin
            if (p == s0_at) repeat (s0_len) step(1'b0);
            if (p == s1_at) repeat (s1_len) step(1'b0);
            step(1'b1);
        end
        if (hold_after) repeat (38 + MAC_LAT) step(1'b1);
        wait_done(start_cnt);
    endtask

    initial begin : driver
        int fd_before;
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) step(1'b0);

        // Reset held for 10 cycles while idle.
        rst = 1'b1;
        repeat (10) step(1'b0);
        rst = 1'b0;
        repeat (3) step(1'b0);

        send_frame(-1, 0, -1, 0, 1'b0);
        repeat (3) step(1'b0);
        send_frame(50, 5, 194, 1, 1'b0);
        repeat (3) step(1'b0);
        send_frame(-1, 0, -1, 0, 1'b1);
        repeat (6) step(1'b0);
        send_frame(-1, 0, -1, 0, 1'b0);
        repeat (2) step(1'b0);

        // Abort during the readout burst after 10 out_valid cycles.
        fd_before = dut_fd_cnt;
        for (int p = 0; p < NPIX; p++) step(1'b1);
        repeat (14) step(1'b0);
        rst = 1'b1;
        repeat (3) step(1'b0);
        rst = 1'b0;
        repeat (10) step(1'b0);
        chk("no_frame_done_after_abort", dut_fd_cnt, fd_before);

        send_frame(-1, 0, -1, 0, 1'b0);
        repeat (3) step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
